// File: rtl/mips_mc_ctrl_if.sv
// Control/handshake bundle between the multicycle control FSM and the datapath/memory.
interface mips_mc_ctrl_if;
  // Inputs to the controller
  logic        run;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        mem_ready;
  // Outputs from the controller
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_we;
  logic        pc_we;
  logic [1:0]  pc_src;
  logic [3:0]  alu_ctrl;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic        reg_we;
  logic [1:0]  reg_dst;
  logic [1:0]  wb_src;
  logic        instr_done;
  logic        illegal;
  logic [31:0] retired;

  // Controller side
  modport master (
    input  run, opcode, funct, mem_ready,
    output mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_ctrl, alu_src_a,
           alu_src_b, reg_we, reg_dst, wb_src, instr_done, illegal, retired
  );

  // Datapath / environment side
  modport slave (
    output run, opcode, funct, mem_ready,
    input  mem_req, mem_we, iord, ir_we, pc_we, pc_src, alu_ctrl, alu_src_a,
           alu_src_b, reg_we, reg_dst, wb_src, instr_done, illegal, retired
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS main control FSM: sequences fetch/decode/execute/memory/write-back
// for addiu, addu, lw, sw and jal; any other instruction parks the core in TRAP.
module mips_mc_ctrl #(
  parameter logic [5:0] OP_RTYPE = 6'h00,
  parameter logic [5:0] OP_JAL   = 6'h03,
  parameter logic [5:0] OP_ADDIU = 6'h09,
  parameter logic [5:0] OP_LW    = 6'h23,
  parameter logic [5:0] OP_SW    = 6'h2B,
  parameter logic [5:0] FN_ADDU  = 6'h21
) (
  input  logic           clk,
  input  logic           rst_n,
  mips_mc_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    ADDR   = 4'd3,
    MEM_RD = 4'd4,
    LW_WB  = 4'd5,
    MEM_WR = 4'd6,
    EXEC_I = 4'd7,
    WB_I   = 4'd8,
    EXEC_R = 4'd9,
    WB_R   = 4'd10,
    JUMP   = 4'd11,
    TRAP   = 4'd12
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] retired_q, retired_d;
  logic        done_w;

  // After a completing cycle: continue with the next fetch or park in IDLE.
  state_t      after_done;
  assign after_done = bus.run ? FETCH : IDLE;

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; mem_ready only matters in FETCH, MEM_RD and MEM_WR.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (bus.run) state_d = FETCH;
      FETCH:  if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        if (bus.opcode == OP_LW || bus.opcode == OP_SW)            state_d = ADDR;
        else if (bus.opcode == OP_ADDIU)                           state_d = EXEC_I;
        else if (bus.opcode == OP_RTYPE && bus.funct == FN_ADDU)   state_d = EXEC_R;
        else if (bus.opcode == OP_JAL)                             state_d = JUMP;
        else                                                       state_d = TRAP;
      end
      // Only lw/sw reach ADDR, so a non-lw opcode here is sw.
      ADDR:   state_d = (bus.opcode == OP_LW) ? MEM_RD : MEM_WR;
      MEM_RD: if (bus.mem_ready) state_d = LW_WB;
      MEM_WR: if (bus.mem_ready) state_d = after_done;
      EXEC_I: state_d = WB_I;
      EXEC_R: state_d = WB_R;
      LW_WB, WB_I, WB_R, JUMP: state_d = after_done;
      TRAP:   state_d = TRAP;
      default: state_d = IDLE;
    endcase
  end

  // Moore output decode; ir_we/pc_we in FETCH and completion in MEM_WR wait for mem_ready.
  always_comb begin
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.iord      = 1'b0;
    bus.ir_we     = 1'b0;
    bus.pc_we     = 1'b0;
    bus.pc_src    = 2'b00;
    bus.alu_ctrl  = 4'b0000;
    bus.alu_src_a = 1'b0;
    bus.alu_src_b = 2'b00;
    bus.reg_we    = 1'b0;
    bus.reg_dst   = 2'b00;
    bus.wb_src    = 2'b00;
    bus.illegal   = 1'b0;
    done_w        = 1'b0;
    case (state_q)
      FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = 2'b01;
        bus.alu_ctrl  = 4'b0010;
        bus.ir_we     = bus.mem_ready;
        bus.pc_we     = bus.mem_ready;
      end
      ADDR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
        bus.alu_ctrl  = (bus.opcode == OP_LW) ? 4'b0100 : 4'b0001;
      end
      MEM_RD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
      end
      LW_WB: begin
        bus.reg_we = 1'b1;
        bus.wb_src = 2'b01;
        done_w     = 1'b1;
      end
      MEM_WR: begin
        bus.mem_req = 1'b1;
        bus.mem_we  = 1'b1;
        bus.iord    = 1'b1;
        done_w      = bus.mem_ready;
      end
      EXEC_I: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = 2'b10;
      end
      WB_I: begin
        bus.reg_we = 1'b1;
        done_w     = 1'b1;
      end
      EXEC_R: begin
        bus.alu_ctrl  = 4'b0010;
        bus.alu_src_a = 1'b1;
      end
      WB_R: begin
        bus.reg_we  = 1'b1;
        bus.reg_dst = 2'b01;
        done_w      = 1'b1;
      end
      // PC still holds PC+4 here, so $31 receives the link address.
      JUMP: begin
        bus.alu_ctrl = 4'b0011;
        bus.pc_we    = 1'b1;
        bus.pc_src   = 2'b10;
        bus.reg_we   = 1'b1;
        bus.reg_dst  = 2'b10;
        bus.wb_src   = 2'b10;
        done_w       = 1'b1;
      end
      TRAP:    bus.illegal = 1'b1;
      default: ;
    endcase
  end

  assign bus.instr_done = done_w;
  assign bus.retired    = retired_q;

  // Retired-instruction count, wrapping naturally at 2^32.
  always_comb begin
    retired_d = retired_q;
    if (done_w) retired_d = retired_q + 32'd1;
  end

  // Retired counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) retired_q <= 32'd0;
    else        retired_q <= retired_d;
  end

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Scoreboard bench for mips_mc_ctrl: stimulus queues per-instruction expectations,
// a monitor measures each instruction from FETCH to instr_done and compares.
module tb_mips_mc_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mips_mc_ctrl_if bus();

  mips_mc_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int          lat;
    int          irc;
    int          pcc;
    logic [31:0] seq;
    logic [7:0]  sig;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   nvec  = 0;
  int   nfail = 0;
  int   fw    = 0;
  int   dw    = 0;

  logic [21:0] outs;
  assign outs = {bus.mem_req, bus.mem_we, bus.iord, bus.ir_we, bus.pc_we, bus.pc_src,
                 bus.alu_ctrl, bus.alu_src_a, bus.alu_src_b, bus.reg_we, bus.reg_dst,
                 bus.wb_src, bus.instr_done, bus.illegal};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory responder: the n-th cycle of a request completes after the programmed wait count.
  initial begin
    int cnt;
    cnt = 0;
    bus.mem_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n || !bus.mem_req) begin
        cnt = 0;
        bus.mem_ready = 1'b0;
      end else if (cnt == (bus.iord ? dw : fw)) begin
        cnt = 0;
        bus.mem_ready = 1'b1;
      end else begin
        cnt++;
        bus.mem_ready = 1'b0;
      end
    end
  end

  // Monitor: tracks each instruction from its first FETCH cycle to instr_done.
  initial begin
    bit          busy;
    int          cyc, irc, pcc;
    logic [31:0] seq;
    exp_t        e;
    busy = 0; cyc = 0; irc = 0; pcc = 0; seq = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        busy = 0;
      end else begin
        if (!busy && bus.mem_req && !bus.iord) begin
          busy = 1; cyc = 0; irc = 0; pcc = 0; seq = '0;
        end
        if (busy) begin
          if (cyc < 8) seq[31-4*cyc -: 4] = bus.alu_ctrl;
          irc += int'(bus.ir_we);
          pcc += int'(bus.pc_we);
          if (bus.instr_done) begin
            if (q.size() == 0) begin
              nvec++; nfail++;
              $display("FAIL unexpected_done: got instr_done=1 expected no completion");
            end else begin
              e = q.pop_front();
              chk("latency",  32'(cyc + 1), 32'(e.lat));
              chk("ir_we_cnt", 32'(irc), 32'(e.irc));
              chk("pc_we_cnt", 32'(pcc), 32'(e.pcc));
              chk("alu_seq",  seq, e.seq);
              chk("done_sig", 32'({bus.reg_we, bus.reg_dst, bus.wb_src, bus.pc_src, bus.mem_we}),
                  32'(e.sig));
              chk("retired",  bus.retired + 32'd1, e.ret);
            end
            busy = 0;
          end else begin
            cyc++;
          end
        end
      end
    end
  end

  task automatic setop(input logic [5:0] op, input logic [5:0] fn, input int f, input int d);
    bus.opcode = op; bus.funct = fn; fw = f; dw = d;
  endtask

  // sig = {reg_we, reg_dst, wb_src, pc_src, mem_we}; ret = retired value after completion.
  task automatic push(input int lat, input int irc, input int pcc, input logic [31:0] seq,
                      input logic [7:0] sig, input logic [31:0] ret);
    exp_t e;
    e.lat = lat; e.irc = irc; e.pcc = pcc; e.seq = seq; e.sig = sig; e.ret = ret;
    q.push_back(e);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk); #2;
      if (bus.instr_done) return;
    end
    nvec++; nfail++;
    $display("FAIL wait_done: got no instr_done expected one within 200 cycles");
  endtask

  // Directed stimulus sequence.
  initial begin
    bit found;
    rst_n = 1'b0;
    bus.run = 1'b0;
    setop(6'h00, 6'h00, 0, 0);
    repeat (3) @(negedge clk);
    #2;
    chk("reset_outs", 32'(outs), 32'd0);
    chk("reset_retired", bus.retired, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("idle_outs", 32'(outs), 32'd0);

    // addiu, no waits
    setop(6'h09, 6'h00, 0, 0);
    push(4, 1, 1, 32'h2000_0000, 8'h80, 32'd1);
    bus.run = 1'b1;
    wait_done();

    // lw with 2 fetch waits and 3 data waits
    setop(6'h23, 6'h00, 2, 3);
    push(10, 1, 1, 32'h2220_4000, 8'h88, 32'd2);
    wait_done();

    // jal
    setop(6'h03, 6'h00, 0, 0);
    push(3, 1, 2, 32'h2030_0000, 8'hD4, 32'd3);
    wait_done();

    // sw
    setop(6'h2B, 6'h00, 0, 0);
    push(4, 1, 1, 32'h2010_0000, 8'h01, 32'd4);
    wait_done();

    // addu with run dropped during EXEC_R
    setop(6'h00, 6'h21, 0, 0);
    push(4, 1, 1, 32'h2020_0000, 8'hA0, 32'd5);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (bus.alu_src_a && bus.alu_src_b == 2'b00 && bus.alu_ctrl == 4'b0010) found = 1;
    end
    chk("exec_r_seen", 32'(found), 32'd1);
    bus.run = 1'b0;
    wait_done();
    @(negedge clk); #2;
    chk("idle_after_run0", 32'(outs), 32'd0);
    @(negedge clk); #2;
    chk("idle_hold", 32'(outs), 32'd0);

    // run raised: FETCH on the next edge, another addu
    setop(6'h00, 6'h21, 0, 0);
    push(4, 1, 1, 32'h2020_0000, 8'hA0, 32'd6);
    bus.run = 1'b1;
    @(negedge clk); #2;
    chk("fetch_after_run", 32'({bus.mem_req, bus.iord}), 32'h2);
    wait_done();

    // unsupported R-type funct 0x20 -> TRAP
    setop(6'h00, 6'h20, 0, 0);
    repeat (5) @(negedge clk);
    #2;
    chk("trap_illegal", 32'(bus.illegal), 32'd1);
    chk("trap_retired", bus.retired, 32'd6);
    chk("trap_quiet", 32'({bus.mem_req, bus.reg_we, bus.instr_done}), 32'd0);
    bus.run = 1'b0;
    repeat (3) @(negedge clk);
    bus.run = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    chk("trap_sticky", 32'(bus.illegal), 32'd1);
    chk("trap_retired_hold", bus.retired, 32'd6);

    // reset clears trap
    rst_n = 1'b0;
    #1;
    chk("reset_illegal", 32'(bus.illegal), 32'd0);
    chk("reset_retired2", bus.retired, 32'd0);
    setop(6'h2B, 6'h00, 0, 0);
    push(4, 1, 1, 32'h2010_0000, 8'h01, 32'd1);
    @(negedge clk); #2;
    rst_n = 1'b1;
    wait_done();

    // sw with long data wait, reset in the middle of MEM_WR
    setop(6'h2B, 6'h00, 0, 40);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk); #2;
      if (bus.mem_we) found = 1;
    end
    chk("mem_wr_seen", 32'(found), 32'd1);
    @(negedge clk); #3;
    chk("mem_wr_active", 32'({bus.mem_req, bus.mem_we}), 32'h3);
    rst_n = 1'b0;
    #1;
    chk("abort_mem_req", 32'(bus.mem_req), 32'd0);
    chk("abort_mem_we", 32'(bus.mem_we), 32'd0);
    chk("abort_retired", bus.retired, 32'd0);
    bus.run = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #2;
      chk("post_reset_idle", 32'(outs), 32'd0);
    end
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multicycle main control FSM for the MIPS core. It sequences the shared ALU, PC, instruction register, register file and the single memory port through the fetch, decode, execute, memory and write-back steps, one instruction at a time. It drives the 4-bit ALU control code and all datapath mux and write enables, and counts retired instructions. Supported instructions: addiu, addu, lw, sw, jal. Any other instruction traps.

## Interface
Parameters:
- OP_RTYPE, 6'h00, R-type opcode
- OP_JAL, 6'h03, jal opcode
- OP_ADDIU, 6'h09, addiu opcode
- OP_LW, 6'h23, lw opcode
- OP_SW, 6'h2B, sw opcode
- FN_ADDU, 6'h21, addu funct

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  level; enables instruction execution
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- mem_ready  in  1  memory port completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  memory write (valid with mem_req)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- ir_we  out  1  instruction register load
- pc_we  out  1  PC load
- pc_src  out  2  00 = ALU result, 10 = jump target {PC[31:28], idx, 2'b00}
- alu_ctrl  out  4  0000 addiu, 0001 sw, 0010 addu, 0011 jal, 0100 lw
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 = rt, 01 = const 4, 10 = sign-extended imm16
- reg_we  out  1  register file write
- reg_dst  out  2  00 = rt, 01 = rd, 10 = $31
- wb_src  out  2  00 = ALUOut, 01 = memory data, 10 = PC
- instr_done  out  1  one-cycle pulse in the last cycle of each instruction
- illegal  out  1  sticky trap flag
- retired  out  32  count of completed instructions

## Operation
- States: IDLE, FETCH, DECODE, ADDR, MEM_RD, LW_WB, MEM_WR, EXEC_I, WB_I, EXEC_R, WB_R, JUMP, TRAP.
- Outputs are a Moore decode of the state, except ir_we/pc_we in FETCH and instr_done in the memory states, which are gated by mem_ready. Any output not listed for a state is 0.
- IDLE: all outputs 0. Go to FETCH when run=1.
- FETCH: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_ctrl=0010, pc_src=00.
  - While mem_ready=0: hold in FETCH.
  - When mem_ready=1: ir_we=1 and pc_we=1 in the same cycle, then go to DECODE.
- DECODE: no enables asserted. Next state:
  - lw or sw → ADDR
  - addiu → EXEC_I
  - opcode=OP_RTYPE with funct=FN_ADDU → EXEC_R
  - jal → JUMP
  - anything else → TRAP
- ADDR: alu_src_a=1, alu_src_b=10. alu_ctrl=0100 for lw, 0001 for sw. Next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, iord=1. Hold until mem_ready=1, then go to LW_WB.
- LW_WB: reg_we=1, reg_dst=00, wb_src=01.
- MEM_WR: mem_req=1, mem_we=1, iord=1. Hold until mem_ready=1. Completion is the mem_ready cycle.
- EXEC_I: alu_ctrl=0000, alu_src_a=1, alu_src_b=10. Then WB_I: reg_we=1, reg_dst=00, wb_src=00.
- EXEC_R: alu_ctrl=0010, alu_src_a=1, alu_src_b=00. Then WB_R: reg_we=1, reg_dst=01, wb_src=00.
- JUMP: alu_ctrl=0011, pc_we=1, pc_src=10, reg_we=1, reg_dst=10, wb_src=10.
  - The PC still holds PC+4 from FETCH, so $31 receives the link address.
- Completion cycles: LW_WB, WB_I, WB_R, JUMP, and MEM_WR with mem_ready=1.
  - instr_done=1 and retired increments by 1 (wraps 0xFFFFFFFF → 0).
  - Next state is FETCH if run=1, otherwise IDLE.
- run=0 mid-instruction does not abort; the instruction completes first.
- TRAP: illegal=1. Stays in TRAP until reset; run is ignored. retired does not increment.

## Timing
- Reset (rst_n=0, async): state=IDLE, retired=0, illegal=0, all outputs 0 immediately. State is held while rst_n is low.
  - Reset mid-instruction (including during a mem_req cycle) abandons the access: mem_req drops in the same cycle.
- After reset release with run=1: the first FETCH is at the first rising edge.
- Latency with mem_ready tied high (cycles from FETCH to instr_done inclusive):
  - jal: 3
  - addiu, addu, sw: 4
  - lw: 5
  - Each memory wait cycle adds 1.
- Back-to-back: FETCH of the next instruction is in the cycle after instr_done.
- mem_ready is only sampled in FETCH, MEM_RD and MEM_WR; it is ignored elsewhere.

## Test plan
- Reset: assert rst_n=0 mid-MEM_WR → mem_req and mem_we drop to 0 without a clock edge; retired=0; after release with run=0, state stays IDLE and all outputs stay 0.
- addiu (opcode 0x09), mem_ready=1 → 4 cycles, alu_ctrl 0010/–/0000/–, reg_we in cycle 4 with reg_dst=00, instr_done pulse, retired=1.
- lw (0x23) with 2 fetch wait cycles and 3 data wait cycles → 10 cycles total, ir_we only in the ready cycle, alu_ctrl=0100 in ADDR, wb_src=01 in LW_WB.
- jal (0x03) → 3 cycles, JUMP asserts pc_src=10, reg_dst=10, wb_src=10, alu_ctrl=0011 at once.
- addu (funct 0x21) followed by R-type funct 0x20 → first retires with reg_dst=01; second goes to TRAP, illegal=1 stays set, retired stays 1 until reset.
- run dropped during EXEC_R → WB_R completes, next state IDLE; run raised → FETCH on the next edge.
